// File: rtl/nand_sweep_ctrl.sv
// nand_sweep_ctrl: in-system self-check for the NAND top wrapper.
// Drives the four in_a/in_b vectors, lets each settle, samples out_c,
// and flags whether the collected results match the NAND truth table.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   async active-low reset (release sampled on clk)
//   start    in   sweep request, level-sensitive, sampled in IDLE only
//   drv_a    out  registered drive for top.in_a (idx[1])
//   drv_b    out  registered drive for top.in_b (idx[0])
//   dut_c    in   top.out_c (combinational from the gate)
//   busy     out  high during SETTLE and SAMPLE
//   done     out  one-cycle pulse when a sweep completes
//   result   out  result[i] = dut_c sampled for vector i
//   pass     out  1 iff last sweep gave result == 4'b0111
//   err_cnt  out  saturating failed-sweep count (NAND_SWEEP_ERRCNT_EN only)
//
// Build option: define NAND_SWEEP_ERRCNT_EN to add the err_cnt port.

module nand_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       pass
`ifdef NAND_SWEEP_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] GOLDEN   = 4'b0111;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] res_q, res_d;
    logic       pass_q, pass_d;
    logic       fail;

`ifdef NAND_SWEEP_ERRCNT_EN
    logic [7:0] err_q, err_d;
`endif

    // Verdict of the sweep as it would be with the current sample folded in.
    assign fail = ({dut_c, res_q[2:0]} != GOLDEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            res_q   <= 4'd0;
            pass_q  <= 1'b0;
`ifdef NAND_SWEEP_ERRCNT_EN
            err_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            pass_q  <= pass_d;
`ifdef NAND_SWEEP_ERRCNT_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        pass_d  = pass_q;
`ifdef NAND_SWEEP_ERRCNT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = CNT_LOAD;
                    res_d   = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                res_d[idx_q] = dut_c;
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                    pass_d  = !fail;
`ifdef NAND_SWEEP_ERRCNT_EN
                    if (fail && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
`endif
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_DONE: begin
                // idx doubles as the drive register, so clearing it
                // returns drv_a/drv_b to 0 on entry to IDLE.
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign drv_a  = idx_q[1];
    assign drv_b  = idx_q[0];
    assign busy   = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done   = (state_q == S_DONE);
    assign result = res_q;
    assign pass   = pass_q;
`ifdef NAND_SWEEP_ERRCNT_EN
    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_nand_sweep_ctrl.sv
// tb_nand_sweep_ctrl: two controllers (SETTLE_CYCLES 1 and 3) against a
// timeline model; the gate is a real NAND, stuck-at-1, or a random bit.

module tb_nand_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    int   mode;
    logic rnd;

    logic       drv_a   [2];
    logic       drv_b   [2];
    logic       dut_c   [2];
    logic       busy    [2];
    logic       done    [2];
    logic [3:0] result  [2];
    logic       pass    [2];
`ifdef NAND_SWEEP_ERRCNT_EN
    logic [7:0] err_cnt [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_gate
        assign dut_c[g] = (mode == 2) ? rnd :
                          (mode == 1) ? 1'b1 :
                          ~(drv_a[g] & drv_b[g]);
    end

    nand_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .drv_a  (drv_a[0]),
        .drv_b  (drv_b[0]),
        .dut_c  (dut_c[0]),
        .busy   (busy[0]),
        .done   (done[0]),
        .result (result[0]),
        .pass   (pass[0])
`ifdef NAND_SWEEP_ERRCNT_EN
        ,
        .err_cnt(err_cnt[0])
`endif
    );

    nand_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .drv_a  (drv_a[1]),
        .drv_b  (drv_b[1]),
        .dut_c  (dut_c[1]),
        .busy   (busy[1]),
        .done   (done[1]),
        .result (result[1]),
        .pass   (pass[1])
`ifdef NAND_SWEEP_ERRCNT_EN
        ,
        .err_cnt(err_cnt[1])
`endif
    );

    // Model: k = cycles since the sweep was accepted (0 = idle).
    int         k     [2];
    logic [3:0] mres  [2];
    logic       mpass [2];
    int         merr  [2];

    int compared = 0;
    int mismatched = 0;

    function automatic int sc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic cexp(input int v);
        if (mode == 2) return rnd;
        if (mode == 1) return 1'b1;
        return (v == 3) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0;
            mres[i] = 4'd0;
            mpass[i] = 1'b0;
            merr[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int s, n, v;
            s = sc(i);
            n = 4 * (s + 1);
            if (k[i] == 0) begin
                if (start) begin
                    k[i] = 1;
                    mres[i] = 4'd0;
                    mpass[i] = 1'b0;
                end
            end else if (k[i] <= n) begin
                if (k[i] % (s + 1) == 0) begin
                    v = k[i] / (s + 1) - 1;
                    mres[i][v] = cexp(v);
                    if (v == 3) begin
                        mpass[i] = (mres[i] == 4'b0111);
                        if (!mpass[i] && merr[i] < 255) merr[i]++;
                    end
                end
                k[i]++;
            end else begin
                k[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int s, n, v;
            logic eb, ed;
            s = sc(i);
            n = 4 * (s + 1);
            eb = (k[i] >= 1) && (k[i] <= n);
            ed = (k[i] == n + 1);
            v = eb ? (k[i] - 1) / (s + 1) : (ed ? 3 : 0);
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(eb));
            chk($sformatf("done%0d", i), int'(done[i]), int'(ed));
            chk($sformatf("drv_a%0d", i), int'(drv_a[i]), v / 2);
            chk($sformatf("drv_b%0d", i), int'(drv_b[i]), v % 2);
            chk($sformatf("result%0d", i), int'(result[i]), int'(mres[i]));
            chk($sformatf("pass%0d", i), int'(pass[i]), int'(mpass[i]));
`ifdef NAND_SWEEP_ERRCNT_EN
            chk($sformatf("err_cnt%0d", i), int'(err_cnt[i]), merr[i]);
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int d0, d1, b1, nd0, nd1;
        logic [7:0] drvseq;

        rst_n = 1'b0;
        start = 1'b0;
        mode = 0;
        rnd = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        cycle();

        // Golden sweep with a real NAND.
        start = 1'b1;
        cycle();
        start = 1'b0;
        d0 = -1;
        d1 = -1;
        b1 = 0;
        drvseq = 8'd0;
        for (int c = 1; c <= 20; c++) begin
            if (done[0] && d0 < 0) d0 = c;
            if (done[1] && d1 < 0) d1 = c;
            if (busy[1]) b1++;
            if (c == 1 || c == 3 || c == 5 || c == 7)
                drvseq = {drvseq[5:0], drv_a[0], drv_b[0]};
            cycle();
        end
        chk("lit_done_cyc_s1", d0, 9);
        chk("lit_done_cyc_s3", d1, 17);
        chk("lit_busy_len_s3", b1, 16);
        chk("lit_drv_seq", int'(drvseq), 8'b00011011);
        chk("lit_result_s1", int'(result[0]), 4'b0111);
        chk("lit_pass_s1", int'(pass[0]), 1);
        chk("lit_result_s3", int'(result[1]), 4'b0111);

        // Stuck-at-1 gate, twice.
        mode = 1;
        for (int r = 1; r <= 2; r++) begin
            start = 1'b1;
            cycle();
            start = 1'b0;
            run(20);
            chk("lit_stuck_result", int'(result[0]), 4'b1111);
            chk("lit_stuck_pass", int'(pass[0]), 0);
`ifdef NAND_SWEEP_ERRCNT_EN
            chk("lit_stuck_err", int'(err_cnt[0]), r);
`endif
        end

        // start held high: back-to-back sweeps.
        mode = 0;
        start = 1'b1;
        cycle();
        nd0 = 0;
        nd1 = 0;
        for (int c = 1; c <= 100; c++) begin
            if (done[0]) nd0++;
            if (done[1]) nd1++;
            cycle();
        end
        start = 1'b0;
        chk("lit_b2b_done_s1", nd0, 10);
        chk("lit_b2b_done_s3", nd1, 5);
        run(20);

        // Reset in cycle 5 of a sweep.
        start = 1'b1;
        cycle();
        start = 1'b0;
        run(4);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_busy", int'(busy[0]) + int'(busy[1]), 0);
        chk("lit_rst_drv", int'(drv_a[0]) + int'(drv_b[0])
                           + int'(drv_a[1]) + int'(drv_b[1]), 0);
        chk("lit_rst_result", int'(result[0]) + int'(result[1]), 0);
        chk("lit_rst_pass", int'(pass[0]) + int'(pass[1]), 0);
        model_reset();
        compare_all();
        run(2);
        rst_n = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        run(20);
        chk("lit_after_rst_pass", int'(pass[0]), 1);

        // Random start, gate mode and random gate bit.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 4) == 0;
            rnd = 1'($urandom % 2);
            if ($urandom % 50 == 0) mode = int'($urandom % 3);
            cycle();
        end
        start = 1'b0;
        run(20);

        // Saturation: enough failing sweeps for both instances.
        mode = 1;
        start = 1'b1;
        run(256 * 18 + 10);
        start = 1'b0;
        run(20);
`ifdef NAND_SWEEP_ERRCNT_EN
        chk("lit_sat_s1", int'(err_cnt[0]), 255);
        chk("lit_sat_s3", int'(err_cnt[1]), 255);
`endif
        chk("lit_sat_pass", int'(pass[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
